// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Shares NUM_CDB common-data-bus writeback ports among NUM_REQ result
//   sources (ALU0, ALU1, MDU, LSU). Each cycle the scan starts at a rotating
//   pointer and grants the first NUM_CDB valid requesters; the j-th winner in
//   scan order is registered onto CDB port j for exactly one cycle. A
//   saturating counter records cycles where demand exceeded CDB bandwidth.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 6,
  parameter int ROB_W   = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*ROB_W-1:0]    req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  output logic [NUM_CDB*ROB_W-1:0]    cdb_rob_idx,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic [CNT_W-1:0]            conflict_cnt
);

  // Pointer is at least one bit wide so a single-requester build still elaborates.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Number of requesters currently holding a result.
  function automatic int popcount(input logic [NUM_REQ-1:0] vec);
    int count;
    count = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      count = count + int'(vec[i]);
    end
    return count;
  endfunction

  // Successor of a requester index, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    return (int'(idx) >= NUM_REQ - 1) ? '0 : (idx + PTR_W'(1));
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]          rr_ptr_q,       rr_ptr_d;
  logic [NUM_CDB-1:0]        cdb_valid_q,    cdb_valid_d;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_q,      cdb_tag_d;
  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_idx_q,  cdb_rob_idx_d;
  logic [NUM_CDB*DATA_W-1:0] cdb_data_q,     cdb_data_d;
  logic [CNT_W-1:0]          conflict_cnt_q, conflict_cnt_d;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0]              grant_s;
  logic [NUM_CDB-1:0]              port_vld_s;
  logic [NUM_CDB-1:0][PTR_W-1:0]   port_src_s;
  logic [PTR_W-1:0]                last_src_s;
  logic                            any_grant_s;
  logic                            oversubscribed_s;

  // Rotating scan from rr_ptr: the first NUM_CDB valid requesters win, in scan order per port.
  always_comb begin
    int               n_granted;
    int               scan;
    logic [PTR_W-1:0] idx;
    logic             take;

    grant_s    = '0;
    port_vld_s = '0;
    port_src_s = '0;
    last_src_s = rr_ptr_q;
    n_granted  = 0;
    scan       = 0;
    idx        = '0;
    take       = 1'b0;

    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      scan = (scan >= NUM_REQ) ? (scan - NUM_REQ) : scan;
      idx  = PTR_W'(scan);
      // Flush kills every grant; a requester only wins while a port is still free.
      take = !flush && req_valid[idx] && (n_granted < NUM_CDB);

      for (int j = 0; j < NUM_CDB; j++) begin
        port_vld_s[j] = port_vld_s[j] | (take && (n_granted == j));
        port_src_s[j] = (take && (n_granted == j)) ? idx : port_src_s[j];
      end

      grant_s[idx] = grant_s[idx] | take;
      last_src_s   = take ? idx : last_src_s;
      n_granted    = n_granted + int'(take);
    end
  end

  assign any_grant_s = |grant_s;

  // Grants are visible to requesters in the same cycle, but never while reset is held.
  always_comb begin
    req_ready = rst_n ? grant_s : '0;
  end

  // Pointer moves just past the last winner so the next scan starts with the first loser.
  always_comb begin
    rr_ptr_d = any_grant_s ? wrap_inc(last_src_s) : rr_ptr_q;
  end

  // -------------------------------------------------------------------------
  // CDB payload steering
  // -------------------------------------------------------------------------
  // Route each winner's payload to its port; idle ports carry zeros so the bus is quiet.
  always_comb begin
    cdb_valid_d   = '0;
    cdb_tag_d     = '0;
    cdb_rob_idx_d = '0;
    cdb_data_d    = '0;
    for (int j = 0; j < NUM_CDB; j++) begin
      if (port_vld_s[j]) begin
        cdb_valid_d[j]                       = 1'b1;
        cdb_tag_d[j*TAG_W +: TAG_W]          = req_tag[int'(port_src_s[j])*TAG_W +: TAG_W];
        cdb_rob_idx_d[j*ROB_W +: ROB_W]      = req_rob_idx[int'(port_src_s[j])*ROB_W +: ROB_W];
        cdb_data_d[j*DATA_W +: DATA_W]       = req_data[int'(port_src_s[j])*DATA_W +: DATA_W];
      end else begin
        cdb_valid_d[j]                       = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Conflict counter
  // -------------------------------------------------------------------------
  // Count cycles where demand exceeds CDB bandwidth; hold at all-ones instead of wrapping.
  always_comb begin
    oversubscribed_s = popcount(req_valid) > NUM_CDB;
    if (!flush && oversubscribed_s && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // Arbitration pointer; restarts at requester 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // CDB broadcast register: one-cycle pulse per grant, no backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q   <= '0;
      cdb_tag_q     <= '0;
      cdb_rob_idx_q <= '0;
      cdb_data_q    <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_data_q    <= cdb_data_d;
    end
  end

  // Performance counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_rob_idx  = cdb_rob_idx_q;
  assign cdb_data     = cdb_data_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for cdb_arbiter: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [23:0] req_tag;
  logic [19:0] req_rob_idx;
  logic [127:0] req_data;

  logic [3:0]  req_ready;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [9:0]  cdb_rob_idx;
  logic [63:0] cdb_data;
  logic [15:0] conflict_cnt;

  logic [3:0]  s_req_ready;
  logic [1:0]  s_cdb_valid;
  logic [11:0] s_cdb_tag;
  logic [9:0]  s_cdb_rob_idx;
  logic [63:0] s_cdb_data;
  logic [3:0]  s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .TAG_W(6), .ROB_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_rob_idx(req_rob_idx), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data), .conflict_cnt(conflict_cnt)
  );

  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .TAG_W(6), .ROB_W(5), .DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_rob_idx(req_rob_idx), .req_data(req_data),
    .req_ready(s_req_ready), .cdb_valid(s_cdb_valid), .cdb_tag(s_cdb_tag),
    .cdb_rob_idx(s_cdb_rob_idx), .cdb_data(s_cdb_data), .conflict_cnt(s_conflict_cnt)
  );

  // Requester i: tag 0x10+i, rob 8+i, data 0x100+i.
  task automatic load_payload();
    for (int i = 0; i < 4; i++) begin
      req_tag[i*6 +: 6]      = 6'h10 + 6'(i);
      req_rob_idx[i*5 +: 5]  = 5'd8 + 5'(i);
      req_data[i*32 +: 32]   = 32'h100 + 32'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 4'b1111; load_payload();
    tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_cdb_valid got %b exp %b", cdb_valid, 2'b00); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conflict got %0d exp 0", conflict_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (cdb_tag !== 12'h000) begin errors++; $display("FAIL reset_cdb_tag got %h exp 000", cdb_tag); end
    req_valid = 4'b0000; rst_n = 1'b1;
    tick(); tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL idle_cdb_valid got %b exp 00", cdb_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_req_ready got %b exp 0000", req_ready); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL idle_rr_ptr got %0d exp 0", dut.rr_ptr_q); end
  endtask

  task automatic test_single();
    req_tag[12 +: 6] = 6'h15; req_rob_idx[10 +: 5] = 5'd7; req_data[64 +: 32] = 32'd42;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 2'b01) begin errors++; $display("FAIL single_cdb_valid got %b exp 01", cdb_valid); end
    checks++; if (cdb_tag[5:0] !== 6'h15) begin errors++; $display("FAIL single_tag got %h exp 15", cdb_tag[5:0]); end
    checks++; if (cdb_data[31:0] !== 32'd42) begin errors++; $display("FAIL single_data got %0d exp 42", cdb_data[31:0]); end
    checks++; if (cdb_rob_idx[4:0] !== 5'd7) begin errors++; $display("FAIL single_rob got %0d exp 7", cdb_rob_idx[4:0]); end
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL single_rr_ptr got %0d exp 3", dut.rr_ptr_q); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_pulse got %b exp 00", cdb_valid); end
    load_payload();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c1_ready got %b exp 0011", req_ready); end
    tick();
    checks++; if (cdb_valid !== 2'b11) begin errors++; $display("FAIL rr_c1_valid got %b exp 11", cdb_valid); end
    checks++; if (cdb_tag !== {6'h11, 6'h10}) begin errors++; $display("FAIL rr_c1_tag got %h exp %h", cdb_tag, {6'h11, 6'h10}); end
    checks++; if (cdb_data[63:32] !== 32'h101) begin errors++; $display("FAIL rr_c1_data1 got %h exp 101", cdb_data[63:32]); end
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL rr_c1_cnt got %0d exp 1", conflict_cnt); end
    checks++; if (req_ready !== 4'b1100) begin errors++; $display("FAIL rr_c2_ready got %b exp 1100", req_ready); end
    tick();
    checks++; if (cdb_tag !== {6'h13, 6'h12}) begin errors++; $display("FAIL rr_c2_tag got %h exp %h", cdb_tag, {6'h13, 6'h12}); end
    checks++; if (cdb_rob_idx[9:5] !== 5'd11) begin errors++; $display("FAIL rr_c2_rob1 got %0d exp 11", cdb_rob_idx[9:5]); end
    checks++; if (conflict_cnt !== 16'd2) begin errors++; $display("FAIL rr_c2_cnt got %0d exp 2", conflict_cnt); end
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c3_ready got %b exp 0011", req_ready); end
    tick();
    checks++; if (cdb_tag !== {6'h11, 6'h10}) begin errors++; $display("FAIL rr_c3_tag got %h exp %h", cdb_tag, {6'h11, 6'h10}); end
    checks++; if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL rr_c3_cnt got %0d exp 3", conflict_cnt); end
    checks++; if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL rr_c3_ptr got %0d exp 2", dut.rr_ptr_q); end
    req_valid = 4'b0000;
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_pre_ready got %b exp 0100", req_ready); end
    tick();
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL wrap_pre_ptr got %0d exp 3", dut.rr_ptr_q); end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL wrap_ready got %b exp 1001", req_ready); end
    tick();
    checks++; if (cdb_valid !== 2'b11) begin errors++; $display("FAIL wrap_valid got %b exp 11", cdb_valid); end
    checks++; if (cdb_tag !== {6'h10, 6'h13}) begin errors++; $display("FAIL wrap_tag got %h exp %h", cdb_tag, {6'h10, 6'h13}); end
    checks++; if (cdb_data[31:0] !== 32'h103) begin errors++; $display("FAIL wrap_data0 got %h exp 103", cdb_data[31:0]); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL wrap_ptr got %0d exp 1", dut.rr_ptr_q); end
    checks++; if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL wrap_cnt got %0d exp 3", conflict_cnt); end
  endtask

  task automatic test_flush();
    req_valid = 4'b1111; flush = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b exp 0000", req_ready); end
    checks++; if (cdb_valid !== 2'b11) begin errors++; $display("FAIL flush_inflight got %b exp 11", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_killed got %b exp 00", cdb_valid); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL flush_ptr got %0d exp 1", dut.rr_ptr_q); end
    checks++; if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL flush_cnt got %0d exp 3", conflict_cnt); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL post_flush_ready got %b exp 0110", req_ready); end
    tick();
    checks++; if (cdb_tag !== {6'h12, 6'h11}) begin errors++; $display("FAIL post_flush_tag got %h exp %h", cdb_tag, {6'h12, 6'h11}); end
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL post_flush_cnt got %0d exp 4", conflict_cnt); end
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL post_flush_ptr got %0d exp 3", dut.rr_ptr_q); end
    req_valid = 4'b0000;
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 4'b1111;
    repeat (15) tick();
    checks++; if (s_conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat15_cnt got %h exp F", s_conflict_cnt); end
    checks++; if (conflict_cnt !== 16'd15) begin errors++; $display("FAIL wide15_cnt got %0d exp 15", conflict_cnt); end
    repeat (5) tick();
    checks++; if (s_conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat20_cnt got %h exp F", s_conflict_cnt); end
    checks++; if (conflict_cnt !== 16'd20) begin errors++; $display("FAIL wide20_cnt got %0d exp 20", conflict_cnt); end
    checks++; if (cdb_valid !== 2'b11) begin errors++; $display("FAIL sat_busy_valid got %b exp 11", cdb_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (s_conflict_cnt !== 4'h0) begin errors++; $display("FAIL async_sat_cnt got %h exp 0", s_conflict_cnt); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt got %0d exp 0", conflict_cnt); end
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL async_valid got %b exp 00", cdb_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL async_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rearb_ready got %b exp 0011", req_ready); end
    tick();
    checks++; if (cdb_tag !== {6'h11, 6'h10}) begin errors++; $display("FAIL rearb_tag got %h exp %h", cdb_tag, {6'h11, 6'h10}); end
    checks++; if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL rearb_ptr got %0d exp 2", dut.rr_ptr_q); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
